btn_debounce_bank: RTL

BTN_DEBOUNCE_BANK -- requirements
Module: btn_debounce_bank

---
 rtl/debounce_pkg.sv | 34 +++
 rtl/debounce_ch.sv | 149 ++++++++++++++
 rtl/btn_debounce_bank.sv | 76 +++++++
 3 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_pkg
//  Description : Shared constants, settle-state encoding and counter-width
//                helper for the button/switch debounce bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    // Default settle length: consecutive agreeing samples before a new level
    // is accepted.
    localparam int unsigned c_DEF_DB_CYCLES   = 100000;

    // Default long-press threshold in held clock cycles.
    localparam int unsigned c_DEF_LONG_CYCLES = 200000000;

    // Depth of the input synchronizer chain.
    localparam int unsigned c_SYNC_STAGES     = 2;

    // Per-channel settle state.
    typedef enum logic [0:0] {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } settle_state_t;

    // Bits needed to hold any value in 0..max_count (never less than one).
    function automatic int unsigned cnt_width(input int unsigned max_count);
        int unsigned w;
        w = $clog2(max_count + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_ch
//  Description : One debounce channel: two-flop synchronizer, optional
//                polarity inversion, settle counter with level/edge pulses
//                and an optional saturating long-press detector.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = c_DEF_DB_CYCLES,
    parameter int unsigned LONG_CYCLES = c_DEF_LONG_CYCLES,
    parameter bit          LONG_EN     = 1'b0,
    parameter bit          INVERT      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_long
);

    // The settle counter only ever counts up to DB_CYCLES-1: the sample that
    // would make it DB_CYCLES is the one that accepts the new level.
    localparam int unsigned        c_CNT_W    = cnt_width(DB_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DB_CYCLES - 1);

    logic [c_SYNC_STAGES-1:0] r_sync;
    logic [c_SYNC_STAGES-1:0] r_primed;
    logic                     w_in;
    logic                     w_primed;

    settle_state_t            r_state;
    logic [c_CNT_W-1:0]       r_cnt;
    logic                     r_level;
    logic                     r_rise;
    logic                     r_fall;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[c_SYNC_STAGES-2:0], i_raw};
        end
    end

    // Marks when the synchronizer holds real pin samples instead of reset
    // zeros; otherwise an inverted button would look pressed for the first
    // two cycles after reset and could be falsely accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_primed <= '0;
        end else begin
            r_primed <= {r_primed[c_SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_primed = r_primed[c_SYNC_STAGES-1];

    // Polarity correction happens after synchronization so both flops see
    // the raw pin.
    assign w_in = r_sync[c_SYNC_STAGES-1] ^ INVERT;

    // Settle FSM: any disagreement starts a count, any agreement abandons it,
    // DB_CYCLES consecutive disagreeing samples flip the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_primed) begin
                case (r_state)
                    ST_STABLE: begin
                        if (w_in != r_level) begin
                            r_state <= ST_SETTLING;
                            r_cnt   <= c_CNT_ONE;
                        end
                    end
                    ST_SETTLING: begin
                        if (w_in == r_level) begin
                            // Bounce back to the old level: discard progress.
                            r_state <= ST_STABLE;
                            r_cnt   <= '0;
                        end else if (r_cnt == c_CNT_LAST) begin
                            r_state <= ST_STABLE;
                            r_cnt   <= '0;
                            r_level <= w_in;
                            r_rise  <= w_in;
                            r_fall  <= ~w_in;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                    default: begin
                        r_state <= ST_STABLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

    if (LONG_EN) begin : g_long
        localparam int unsigned         c_HOLD_W   = cnt_width(LONG_CYCLES);
        localparam logic [c_HOLD_W-1:0] c_HOLD_ONE = c_HOLD_W'(1);
        localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(LONG_CYCLES);
        localparam logic [c_HOLD_W-1:0] c_HOLD_PRE = c_HOLD_W'(LONG_CYCLES - 1);

        logic [c_HOLD_W-1:0] r_hold;
        logic                r_long;

        // Hold timer: counts pressed cycles, saturates at the threshold so the
        // long pulse fires once per press, and clears whenever released.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_hold <= '0;
                r_long <= 1'b0;
            end else begin
                r_long <= 1'b0;
                if (!r_level) begin
                    r_hold <= '0;
                end else if (r_hold != c_HOLD_MAX) begin
                    r_hold <= r_hold + c_HOLD_ONE;
                    r_long <= (r_hold == c_HOLD_PRE);
                end
            end
        end

        assign o_long = r_long;
    end else begin : g_no_long
        assign o_long = 1'b0;
    end

endmodule
`default_nettype wire

// File: rtl/btn_debounce_bank.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce_bank
//  Description : Bank of independent debounce channels for push buttons
//                (with press/release/long-press pulses) and slide switches
//                (with level-change pulses).
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned N_BTN          = 5,
    parameter int unsigned N_SW           = 16,
    parameter int unsigned DB_CYCLES      = c_DEF_DB_CYCLES,
    parameter int unsigned LONG_CYCLES    = c_DEF_LONG_CYCLES,
    parameter int unsigned BTN_ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             RSTN,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_SW-1:0]  sw_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long,
    output logic [N_SW-1:0]  sw_level,
    output logic [N_SW-1:0]  sw_change
);

    localparam bit c_BTN_INVERT = (BTN_ACTIVE_LOW != 0);

    logic [N_SW-1:0] w_sw_rise;
    logic [N_SW-1:0] w_sw_fall;
    logic [N_SW-1:0] w_sw_long_unused;

    // Buttons: inverted to pressed-high, long-press detection enabled.
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_ch #(
            .DB_CYCLES   (DB_CYCLES),
            .LONG_CYCLES (LONG_CYCLES),
            .LONG_EN     (1'b1),
            .INVERT      (c_BTN_INVERT)
        ) u_ch (
            .clk     (clk),
            .rst_n   (RSTN),
            .i_raw   (btn_raw[i]),
            .o_level (btn_level[i]),
            .o_rise  (btn_press[i]),
            .o_fall  (btn_release[i]),
            .o_long  (btn_long[i])
        );
    end

    // Switches: taken at face value, no long-press timer.
    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_ch #(
            .DB_CYCLES   (DB_CYCLES),
            .LONG_CYCLES (LONG_CYCLES),
            .LONG_EN     (1'b0),
            .INVERT      (1'b0)
        ) u_ch (
            .clk     (clk),
            .rst_n   (RSTN),
            .i_raw   (sw_raw[i]),
            .o_level (sw_level[i]),
            .o_rise  (w_sw_rise[i]),
            .o_fall  (w_sw_fall[i]),
            .o_long  (w_sw_long_unused[i])
        );
    end

    // A switch change is any accepted transition, in either direction.
    assign sw_change = w_sw_rise | w_sw_fall;

endmodule
`default_nettype wire
